// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg: shared state encoding and default sizing for the PWM duty scheduler.
package pwm_sched_pkg;
    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
    localparam int DEF_CNT_W = 6;
    localparam int DUTY_W = DEF_CNT_W + 1;
    localparam int DUTY_FULL = 2 ** DEF_CNT_W;
    localparam int CNT_MAX = 2 ** DEF_CNT_W - 1;
endpackage

// File: rtl/pwm_duty_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching last+1 .. last (mod N_REQ).
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] grant_next,
    output logic [IW-1:0]    idx_next
);
    // Walk the order backwards so the requester closest after last wins.
    always_comb begin
        grant_next = '0;
        idx_next = last;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % N_REQ]) begin
                grant_next = '0;
                grant_next[(int'(last) + k) % N_REQ] = 1'b1;
                idx_next = IW'((int'(last) + k) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler: shares one PWM channel among requesters with round-robin grants,
// bounded duty slewing and a minimum hold before re-arbitration.
module pwm_duty_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int N_REQ = 4,
    parameter int RAMP_STEP = 4,
    parameter int HOLD_PERIODS = 8
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic                       Enable,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*(CNT_W+1)-1:0] duty_in,
    output logic [N_REQ-1:0]           grant,
    output logic                       done,
    output logic                       period_start,
    output logic [CNT_W:0]             duty_cur,
    output logic                       Pulse
);
    localparam int DW = CNT_W + 1;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(HOLD_PERIODS + 1);
    localparam logic [DW-1:0] FULL = DW'(2 ** CNT_W);
    localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [IW-1:0]     last, arb_idx;
    logic [N_REQ-1:0]  arb_req, arb_grant;
    logic [DW-1:0]     target, sel, new_target, grant_duty, ramp_duty, decay;
    logic [HW-1:0]     hold_cnt, hold_dec;
    logic              boundary, take, owner_lost;

    function automatic logic [DW-1:0] step_to(input logic [DW-1:0] d, input logic [DW-1:0] t);
        return (t > d) ? ((t - d > STEP) ? d + STEP : t) : ((d - t > STEP) ? d - STEP : t);
    endfunction

    // In HOLD the current owner is masked so it can only win after everyone else.
    assign arb_req = (state == HOLD) ? (req & ~grant) : req;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req(arb_req),
        .last(last),
        .grant_next(arb_grant),
        .idx_next(arb_idx)
    );

    assign boundary = (count == '1);
    assign sel = duty_in[arb_idx*DW +: DW];
    assign new_target = (sel > FULL) ? FULL : sel;
    assign grant_duty = step_to(duty_cur, new_target);
    assign ramp_duty = step_to(duty_cur, target);
    assign decay = (duty_cur > STEP) ? duty_cur - STEP : '0;
    assign hold_dec = (hold_cnt == '0) ? '0 : hold_cnt - 1'b1;
    assign take = (|arb_req) && (state == IDLE || (state == HOLD && hold_dec == '0));
    assign owner_lost = (state != IDLE) && !(|(req & grant));
    assign period_start = (count == '0);
    assign Pulse = Enable && ({1'b0, count} < duty_cur);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            count <= '0;
            state <= IDLE;
            duty_cur <= '0;
            grant <= '0;
            done <= 1'b0;
            last <= IW'(N_REQ - 1);
            target <= '0;
            hold_cnt <= '0;
        end else begin
            count <= count + 1'b1;
            done <= 1'b0;
            if (!Enable) begin
                grant <= '0;
                duty_cur <= '0;
                state <= IDLE;
                hold_cnt <= '0;
            end else if (owner_lost) begin
                grant <= '0;
                state <= IDLE;
            end else if (boundary) begin
                if (take) begin
                    grant <= arb_grant;
                    last <= arb_idx;
                    target <= new_target;
                    duty_cur <= grant_duty;
                    state <= (grant_duty == new_target) ? HOLD : RAMP;
                    hold_cnt <= (grant_duty == new_target) ? HW'(HOLD_PERIODS) : hold_cnt;
                    done <= (grant_duty == new_target);
                end else if (state == IDLE) begin
                    duty_cur <= decay;
                end else if (state == RAMP) begin
                    duty_cur <= ramp_duty;
                    state <= (ramp_duty == target) ? HOLD : RAMP;
                    hold_cnt <= (ramp_duty == target) ? HW'(HOLD_PERIODS) : hold_cnt;
                    done <= (ramp_duty == target);
                end else begin
                    hold_cnt <= hold_dec;
                end
            end
        end
    end
endmodule
